display_sequencer: RTL and testbench

Controller for the four-source debug display path (PC, immediate, ALU result, SR1). It drives the source-select code of the display mux, pages the returned 32-bit value onto a 16-bit, four-hex-digit window (low/high half), and offers manual selection, an auto-rotate mode and a debounced freeze/snapshot button. It sits between the board I/O (switches, key) and the display mux and seven-segment decoders.

---
 rtl/display_pkg.sv | 21 ++
 rtl/display_sequencer_if.sv | 16 +
 rtl/key_debounce.sv | 45 ++++
 rtl/display_sequencer.sv | 124 ++++++++++++
 tb/tb_display_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared types for the debug display path: FSM states, mux source codes and
// the half-word pager used by the sequencer.
package display_pkg;

  typedef enum logic {
    LIVE   = 1'b0,
    FROZEN = 1'b1
  } state_t;

  typedef logic [1:0] src_t;

  localparam src_t SRC_PC  = 2'd0;
  localparam src_t SRC_IMM = 2'd1;
  localparam src_t SRC_ALU = 2'd2;
  localparam src_t SRC_SR1 = 2'd3;

  function automatic logic [15:0] half_sel(input logic [31:0] word, input logic hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/display_sequencer_if.sv
// Display-side bundle: source select to the mux, returned value, and the
// paged half-word plus status going to the hex decoders.
interface display_sequencer_if;
  import display_pkg::*;

  src_t        sel_out;
  logic [31:0] value_in;
  src_t        src_id;
  logic        page;
  logic [15:0] disp_half;
  logic        frozen;

  modport master (output sel_out, src_id, page, disp_half, frozen, input value_in);
  modport slave  (input sel_out, src_id, page, disp_half, frozen, output value_in);

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stability counter for the freeze key; emits a
// one-cycle press pulse on the rising edge of the debounced level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_s1;
  logic          btn_s2;
  logic          level;
  logic [CW-1:0] run;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      level  <= 1'b0;
      run    <= '0;
      press  <= 1'b0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      press  <= 1'b0;
      if (btn_s2 == level) begin
        run <= '0;
      end else if (run == LAST) begin
        // Only a 0->1 acceptance produces a pulse; release is silent.
        level <= btn_s2;
        run   <= '0;
        press <= btn_s2;
      end else begin
        run <= run + CW'(1);
      end
    end
  end

endmodule

// File: rtl/display_sequencer.sv
// Source sequencer for the debug display: manual/auto source selection,
// half-word paging on a dwell tick, and a key-driven freeze snapshot.
module display_sequencer
  import display_pkg::*;
#(
  parameter int TICK_DIV        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          sw_sel,
  input  logic                auto_en,
  input  logic                freeze_btn,
  display_sequencer_if.master disp
);

  localparam int            TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  src_t          sw_s1, sw_s2;
  logic          auto_s1, auto_s2;
  logic          press;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  state_t        state, state_next;
  src_t          sel, sel_next;
  logic          page, page_next;
  logic          cnt_restart;
  logic          snap_load;
  logic [31:0]   snapshot;
  src_t          snap_src;
  logic [15:0]   disp_half;
  src_t          src_id;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk   (clk),
    .rst   (rst),
    .btn   (freeze_btn),
    .press (press)
  );

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= LIVE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (press) state_next = (state == LIVE) ? FROZEN : LIVE;
  end

  // A press outranks everything else in its cycle, including a coincident tick.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    sel_next    = sel;
    page_next   = page;
    cnt_restart = 1'b0;
    snap_load   = 1'b0;
    if (press) begin
      if (state == LIVE) begin
        snap_load = 1'b1;
      end else begin
        page_next   = 1'b0;
        cnt_restart = 1'b1;
      end
    end else if (state == FROZEN) begin
      if (tick) page_next = ~page;
    end else if (auto_s2) begin
      if (tick) begin
        if (page) begin
          page_next = 1'b0;
          sel_next  = sel + 2'd1;
        end else begin
          page_next = 1'b1;
        end
      end
    end else if (sw_s2 != sel) begin
      sel_next    = sw_s2;
      page_next   = 1'b0;
      cnt_restart = 1'b1;
    end else if (tick) begin
      page_next = ~page;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1     <= SRC_PC;
      sw_s2     <= SRC_PC;
      auto_s1   <= 1'b0;
      auto_s2   <= 1'b0;
      tick_cnt  <= '0;
      sel       <= SRC_PC;
      page      <= 1'b0;
      snapshot  <= '0;
      snap_src  <= SRC_PC;
      disp_half <= '0;
      src_id    <= SRC_PC;
    end else begin
      sw_s1    <= sw_sel;
      sw_s2    <= sw_s1;
      auto_s1  <= auto_en;
      auto_s2  <= auto_s1;
      tick_cnt <= (cnt_restart || tick) ? '0 : tick_cnt + TW'(1);
      sel      <= sel_next;
      page     <= page_next;
      if (snap_load) begin
        snapshot <= disp.value_in;
        snap_src <= sel;
      end
      disp_half <= half_sel((state == FROZEN) ? snapshot : disp.value_in, page);
      src_id    <= (state == FROZEN) ? snap_src : sel;
    end
  end

  assign disp.sel_out   = sel;
  assign disp.src_id    = src_id;
  assign disp.page      = page;
  assign disp.disp_half = disp_half;
  assign disp.frozen    = (state == FROZEN);

endmodule

// File: tb/tb_display_sequencer.sv
// Bench for display_sequencer: reset/manual vector table, hand-written
// auto/freeze/bounce/collision sequences, then randomized traffic vs a model.
module tb_display_sequencer;

  localparam int TD = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sw_sel = 2'd0;
  logic       auto_en = 1'b0;
  logic       freeze_btn = 1'b0;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  display_sequencer_if ifc ();

  display_sequencer #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_sel     (sw_sel),
    .auto_en    (auto_en),
    .freeze_btn (freeze_btn),
    .disp       (ifc.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mux(input logic [1:0] s);
    case (s)
      2'd0:    return 32'h1111_2222;
      2'd1:    return 32'h3333_4444;
      2'd2:    return 32'h5555_6666;
      default: return 32'h7777_8888;
    endcase
  endfunction

  assign ifc.value_in = mux(ifc.sel_out);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: sync pipes as 2-deep arrays, a stable-cycle count for the
  // key, and the sequencing rules applied to the pre-edge snapshot of state.
  logic [1:0]  m_sw_p[2];
  logic        m_au_p[2];
  logic        m_bt_p[2];
  logic        m_level = 0, m_press = 0, m_page = 0, m_frozen = 0;
  int          m_run = 0, m_cnt = 0;
  logic [1:0]  m_sel = 0, m_snap_src = 0, m_src = 0;
  logic [31:0] m_snap = 0;
  logic [15:0] m_disp = 0;

  initial begin
    m_sw_p = '{2'd0, 2'd0};
    m_au_p = '{1'b0, 1'b0};
    m_bt_p = '{1'b0, 1'b0};
  end

  always @(posedge clk) begin
    logic        tick, press_n, level_n, page_n, frz_n;
    logic [1:0]  sel_n;
    int          cnt_n, run_n;
    logic [31:0] shown;
    if (rst) begin
      m_sw_p = '{2'd0, 2'd0}; m_au_p = '{1'b0, 1'b0}; m_bt_p = '{1'b0, 1'b0};
      m_level = 0; m_press = 0; m_run = 0; m_cnt = 0; m_page = 0; m_sel = 0;
      m_frozen = 0; m_snap = 0; m_snap_src = 0; m_disp = 0; m_src = 0;
    end else begin
      tick    = (m_cnt == TD - 1);
      level_n = m_level;
      press_n = 1'b0;
      run_n   = 0;
      if (m_bt_p[1] != m_level) begin
        if (m_run + 1 >= DC) begin
          level_n = m_bt_p[1];
          press_n = m_bt_p[1];
        end else begin
          run_n = m_run + 1;
        end
      end
      shown  = m_frozen ? m_snap : mux(m_sel);
      m_disp = m_page ? shown[31:16] : shown[15:0];
      m_src  = m_frozen ? m_snap_src : m_sel;
      cnt_n  = (m_cnt + 1) % TD;
      page_n = m_page;
      sel_n  = m_sel;
      frz_n  = m_frozen;
      if (m_press) begin
        frz_n = !m_frozen;
        if (!m_frozen) begin
          m_snap     = mux(m_sel);
          m_snap_src = m_sel;
        end else begin
          page_n = 0;
          cnt_n  = 0;
        end
      end else if (m_frozen || !m_au_p[1]) begin
        if (!m_frozen && m_sw_p[1] != m_sel) begin
          sel_n  = m_sw_p[1];
          page_n = 0;
          cnt_n  = 0;
        end else if (tick) begin
          page_n = !m_page;
        end
      end else if (tick) begin
        page_n = !m_page;
        if (m_page) sel_n = 2'((m_sel + 1) % 4);
      end
      m_cnt = cnt_n; m_page = page_n; m_sel = sel_n; m_frozen = frz_n;
      m_level = level_n; m_press = press_n; m_run = run_n;
      m_sw_p[1] = m_sw_p[0]; m_sw_p[0] = sw_sel;
      m_au_p[1] = m_au_p[0]; m_au_p[0] = auto_en;
      m_bt_p[1] = m_bt_p[0]; m_bt_p[0] = freeze_btn;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_sel",    32'(ifc.sel_out),   32'(m_sel));
      check("model_page",   32'(ifc.page),      32'(m_page));
      check("model_disp",   32'(ifc.disp_half), 32'(m_disp));
      check("model_src",    32'(ifc.src_id),    32'(m_src));
      check("model_frozen", 32'(ifc.frozen),    32'(m_frozen));
    end
  end

  typedef struct {
    logic        rst;
    logic [1:0]  sw;
    logic [1:0]  e_sel;
    logic        e_page;
    logic [15:0] e_disp;
    logic [1:0]  e_src;
    logic        e_frz;
  } vec_t;

  vec_t tbl[15];

  task automatic wait_page(input logic want, output int n);
    n = 0;
    while (ifc.page !== want && n < 40) begin
      step(1);
      n++;
    end
    check("page_wait", 32'(ifc.page), 32'(want));
  endtask

  initial begin
    int         n;
    int         hold;
    logic [1:0] prev, sel_pre;
    logic [31:0] w;
    bit         got_hi, got_lo, got_other, sel_moved;

    tbl[0]  = '{1, 0, 0, 0, 16'h0000, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 16'h0000, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 16'h2222, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 16'h2222, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 16'h2222, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 16'h2222, 0, 0};
    tbl[6]  = '{0, 0, 0, 1, 16'h1111, 0, 0};
    tbl[7]  = '{0, 2, 0, 1, 16'h1111, 0, 0};
    tbl[8]  = '{0, 2, 0, 1, 16'h1111, 0, 0};
    tbl[9]  = '{0, 2, 2, 0, 16'h1111, 0, 0};
    tbl[10] = '{0, 2, 2, 0, 16'h6666, 2, 0};
    tbl[11] = '{0, 2, 2, 0, 16'h6666, 2, 0};
    tbl[12] = '{0, 2, 2, 0, 16'h6666, 2, 0};
    tbl[13] = '{0, 2, 2, 1, 16'h6666, 2, 0};
    tbl[14] = '{0, 2, 2, 1, 16'h5555, 2, 0};

    for (int i = 0; i < 15; i++) begin
      rst    = tbl[i].rst;
      sw_sel = tbl[i].sw;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_sel", i),    32'(ifc.sel_out),   32'(tbl[i].e_sel));
      check($sformatf("vec%0d_page", i),   32'(ifc.page),      32'(tbl[i].e_page));
      check($sformatf("vec%0d_disp", i),   32'(ifc.disp_half), 32'(tbl[i].e_disp));
      check($sformatf("vec%0d_src", i),    32'(ifc.src_id),    32'(tbl[i].e_src));
      check($sformatf("vec%0d_frozen", i), 32'(ifc.frozen),    32'(tbl[i].e_frz));
      if (i == 0) chk_en = 1'b1;
    end

    // Auto rotation from source 3 with wrap to 0.
    sw_sel = 2'd3;
    step(4);
    check("auto_start_sel", 32'(ifc.sel_out), 32'd3);
    auto_en = 1'b1;
    wait_page(1'b1, n);
    check("auto_sel_p1", 32'(ifc.sel_out), 32'd3);
    wait_page(1'b0, n);
    check("auto_dwell", 32'(n), 32'(TD));
    check("auto_wrap_sel", 32'(ifc.sel_out), 32'd0);
    step(1);
    check("auto_wrap_disp", 32'(ifc.disp_half), 32'h2222);
    step(7);
    check("auto_next_sel", 32'(ifc.sel_out), 32'd1);
    step(24);
    check("auto_rotation_sel", 32'(ifc.sel_out), 32'd0);
    check("auto_rotation_page", 32'(ifc.page), 32'd0);
    auto_en = 1'b0;
    step(3);
    check("auto_off_sel", 32'(ifc.sel_out), 32'd3);

    // Freeze at source 2, switches ignored, then unfreeze.
    sw_sel = 2'd2;
    step(4);
    check("frz_pre_sel", 32'(ifc.sel_out), 32'd2);
    freeze_btn = 1'b1;
    step(6);
    check("frz_on", 32'(ifc.frozen), 32'd1);
    freeze_btn = 1'b0;
    step(1);
    check("frz_src", 32'(ifc.src_id), 32'd2);
    sw_sel = 2'd1;
    got_hi = 0; got_lo = 0; got_other = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (ifc.disp_half === 16'h5555) got_hi = 1;
      else if (ifc.disp_half === 16'h6666) got_lo = 1;
      else got_other = 1;
    end
    check("frz_seen_hi", 32'(got_hi), 32'd1);
    check("frz_seen_lo", 32'(got_lo), 32'd1);
    check("frz_no_other", 32'(got_other), 32'd0);
    check("frz_sel_held", 32'(ifc.sel_out), 32'd2);
    freeze_btn = 1'b1;
    step(6);
    check("unfrz_off", 32'(ifc.frozen), 32'd0);
    freeze_btn = 1'b0;
    step(1);
    check("unfrz_sel", 32'(ifc.sel_out), 32'd1);

    // Bounce: 2-cycle pulses must never be accepted.
    step(8);
    for (int i = 0; i < 8; i++) begin
      freeze_btn = (i % 4) < 2;
      step(1);
      check("bounce_frozen", 32'(ifc.frozen), 32'd0);
    end
    freeze_btn = 1'b0;
    step(8);
    check("bounce_final", 32'(ifc.frozen), 32'd0);

    // Collision: press pulse lands on a tick with page=1 in auto mode.
    auto_en = 1'b1;
    step(3);
    prev = ifc.sel_out;
    n = 0;
    while (ifc.sel_out === prev && n < 40) begin
      step(1);
      n++;
    end
    sel_moved = (ifc.sel_out !== prev);
    check("coll_wait", 32'(sel_moved), 32'd1);
    step(2);
    freeze_btn = 1'b1;
    step(5);
    sel_pre = ifc.sel_out;
    check("coll_pre_page", 32'(ifc.page), 32'd1);
    step(1);
    check("coll_frozen", 32'(ifc.frozen), 32'd1);
    check("coll_sel_held", 32'(ifc.sel_out), 32'(sel_pre));
    check("coll_page_held", 32'(ifc.page), 32'd1);
    freeze_btn = 1'b0;
    step(1);
    w = mux(sel_pre);
    check("coll_snap", 32'(ifc.disp_half), 32'(w[31:16]));
    check("coll_src", 32'(ifc.src_id), 32'(sel_pre));

    // Randomized traffic against the model.
    auto_en = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    hold = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) sw_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) auto_en = ~auto_en;
      if (hold == 0) begin
        freeze_btn = ($urandom_range(0, 2) == 0);
        hold = $urandom_range(1, 9);
      end else begin
        hold--;
      end
      rst = ($urandom_range(0, 399) == 0);
      step(1);
    end
    rst = 1'b0;
    step(1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
